// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with valid/ready request and response handshakes.
module cpu_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg;
  logic [2:0]          op_reg;
  logic [CW-1:0]       cnt_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic [XLEN-1:0]     result_reg;
  logic [TAG_W-1:0]    tag_reg;

  // Operand signedness and magnitudes at accept
  logic            a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                         a_sgn = 1'b1;
      default:                        ;
    endcase
    neg_a       = a_sgn & req_a[XLEN-1];
    neg_b       = b_sgn & req_b[XLEN-1];
    a_mag       = neg_a ? -req_a : req_a;
    b_mag       = neg_b ? -req_b : req_b;
    div_zero    = req_op[2] && (req_b == '0);
    div_ovf     = req_op[2] && !req_op[0] && (req_a == MIN_NEG) && (req_b == '1);
    special_res = req_op[1] ? (div_zero ? req_a : '0) : (div_zero ? '1 : req_a);
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_reg};
    div_diff  = div_shift[XLEN-1:0] - opnd_reg;
    div_next  = div_ge ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    prod_fix  = (sign_a_reg ^ sign_b_reg) ? -mul_next : mul_next;
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if (op_reg[2])
      final_res = op_reg[1] ? (sign_a_reg ? -rem : rem)
                            : ((sign_a_reg ^ sign_b_reg) ? -quo : quo);
    else
      final_res = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      cnt_reg    <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      result_reg <= '0;
      tag_reg    <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          op_reg     <= req_op;
          tag_reg    <= req_tag;
          sign_a_reg <= neg_a;
          sign_b_reg <= neg_b;
          if (div_zero || div_ovf) begin
            result_reg <= special_res;
            state_reg  <= DONE;
          end else begin
            cnt_reg   <= CW'(XLEN);
            opnd_reg  <= req_op[2] ? b_mag : a_mag;
            acc_reg   <= {{XLEN{1'b0}}, (req_op[2] ? a_mag : b_mag)};
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg <= op_reg[2] ? div_next : mul_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            result_reg <= final_res;
            state_reg  <= DONE;
          end
        end
        DONE: if (resp_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign resp_valid  = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign resp_result = result_reg;
  assign resp_tag    = tag_reg;
endmodule

// File: tb/tb_cpu_muldiv.sv
// Scoreboard bench for cpu_muldiv: reference model results are queued at
// accept and compared when the response appears.
module tb_cpu_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        busy;

  cpu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic signed [63:0] p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    p  = '0;
    if (!op[2]) begin
      case (op[1:0])
        2'b00, 2'b01: p = sa * sb;
        2'b10:        p = sa * ub;
        default:      p = ua * ub;
      endcase
      return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op[1:0])
      2'b00:   return ia / ib;
      2'b01:   return a / b;
      2'b10:   return ia % ib;
      default: return a % b;
    endcase
  endfunction

  // Drive a request and wait for the accept edge; leaves the bench just after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("req_ready_timeout", 32'(req_ready), 32'h1);
    @(posedge clk);
    if (push) begin
      e.res = model(op, a, b);
      e.tag = tag;
      e.lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 32;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, scramble request inputs meanwhile, optionally stall.
  task automatic collect(input int hold);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      req_a = $urandom;
      req_b = $urandom;
      req_op = 3'($urandom_range(0, 7));
      if (resp_valid) break;
    end
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'h0, 32'h1);
      return;
    end
    e = sb_q.pop_front();
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("result", resp_result, e.res);
    chk("tag", 32'(resp_tag), 32'(e.tag));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", resp_result, e.res);
      chk("hold_tag", 32'(resp_tag), 32'(e.tag));
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_req_ready", 32'(req_ready), 32'h1);
    chk("idle_resp_valid", 32'(resp_valid), 32'h0);
  endtask

  logic [2:0]  t_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] t_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int seen;
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_result", resp_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i], (i == 0) ? 5'd5 : 5'(i + 8), 1'b1);
      collect((i == 0) ? 10 : 0);
    end

    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, (i == 5) ? 32'd3 : $urandom, 5'($urandom), 1'b1);
      collect(0);
    end

    // Flush after ten CALC cycles
    issue(3'd0, 32'd11, 32'd13, 5'd1, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_ready", 32'(req_ready), 32'h1);
    chk("flush_busy", 32'(busy), 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("flush_no_resp", 32'(seen), 32'h0);

    // Asynchronous reset mid-calculation, checked before any further clock edge
    issue(3'd0, 32'd9, 32'd9, 5'd17, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_req_ready", 32'(req_ready), 32'h1);
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_resp_valid", 32'(resp_valid), 32'h0);
    chk("areset_tag", 32'(resp_tag), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd2, 1'b1);
    collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
